// File: rtl/seq_match_pkg.sv
// Shared definitions for the programmable sequence matcher.
//   - State codes and the FSM state enum.
//   - Bit positions in the character-class vector.
//   - Helpers that turn raw min/max repeat settings into effective ones.
package seq_match_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RUN      = 3'd1;
    localparam logic [2:0] ST_STOP     = 3'd2;
    localparam logic [2:0] ST_ERROR    = 3'd3;
    localparam logic [2:0] ST_ERR_TERM = 3'd4;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StRun     = ST_RUN,
        StStop    = ST_STOP,
        StError   = ST_ERROR,
        StErrTerm = ST_ERR_TERM
    } state_e;

    localparam int unsigned CLS_START_STOP  = 0;
    localparam int unsigned CLS_SMALL       = 1;
    localparam int unsigned CLS_CAPITAL     = 2;
    localparam int unsigned CLS_NUMBER      = 3;
    localparam int unsigned CLS_HEX         = 4;
    localparam int unsigned CLS_PUNCT_BASIC = 5;
    localparam int unsigned CLS_PUNCT_FIN   = 6;
    localparam int unsigned CLS_PAREN       = 7;
    localparam int unsigned CLS_CURLY       = 8;
    localparam int unsigned CLS_MATH        = 9;
    localparam int unsigned CLS_WS          = 10;
    localparam int unsigned CLS_VOWEL       = 11;
    localparam int unsigned CLS_CONSONANT   = 12;
    localparam int unsigned CLS_OTHER       = 13;

    // A minimum of zero would let a step be skipped without consuming input,
    // which greedy matching cannot express, so it is promoted to one.
    function automatic int unsigned clamp_min(input int unsigned raw_min);
        return (raw_min == 0) ? 1 : raw_min;
    endfunction

    function automatic int unsigned clamp_max(input int unsigned raw_max,
                                              input int unsigned raw_min);
        int unsigned eff_min;
        eff_min = clamp_min(raw_min);
        return (raw_max < eff_min) ? eff_min : raw_max;
    endfunction

endpackage

// File: rtl/seq_cfg_table.sv
// Step table for the sequence matcher.
//   clk, rst          : clock, synchronous active-high reset
//   idle              : writes are accepted only while this is high
//   we/addr/mask/min/max : step write port (min/max stored in effective form)
//   len_we/len_in     : pattern length write port (clamped to MAX_STEPS)
//   rd_idx            : current step index
//   rd_mask/min/max   : current step contents
//   nxt_mask          : mask of the step after rd_idx
//   len               : active pattern length
module seq_cfg_table
    import seq_match_pkg::*;
#(
    parameter int unsigned NUM_CLASS = 14,
    parameter int unsigned MAX_STEPS = 8,
    parameter int unsigned CNT_W     = 4,
    localparam int unsigned AW       = $clog2(MAX_STEPS),
    localparam int unsigned LW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 idle,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [NUM_CLASS-1:0] mask,
    input  logic [CNT_W-1:0]     min,
    input  logic [CNT_W-1:0]     max,
    input  logic                 len_we,
    input  logic [LW-1:0]        len_in,
    input  logic [AW-1:0]        rd_idx,
    output logic [NUM_CLASS-1:0] rd_mask,
    output logic [CNT_W-1:0]     rd_min,
    output logic [CNT_W-1:0]     rd_max,
    output logic [NUM_CLASS-1:0] nxt_mask,
    output logic [LW-1:0]        len
);

    logic [NUM_CLASS-1:0] mask_q [MAX_STEPS];
    logic [CNT_W-1:0]     min_q  [MAX_STEPS];
    logic [CNT_W-1:0]     max_q  [MAX_STEPS];
    logic [LW-1:0]        len_q;

    logic [CNT_W-1:0] min_eff;
    logic [CNT_W-1:0] max_eff;
    logic [LW-1:0]    len_eff;
    logic [AW-1:0]    nxt_idx;

    always_comb begin
        min_eff = CNT_W'(clamp_min(32'(min)));
        max_eff = CNT_W'(clamp_max(32'(max), 32'(min)));
        len_eff = (len_in > LW'(MAX_STEPS)) ? LW'(MAX_STEPS) : len_in;
        // The matcher only looks ahead when a next step exists, so wrapping
        // at the top of the table is harmless and keeps the index in range.
        nxt_idx = (rd_idx == AW'(MAX_STEPS - 1)) ? '0 : rd_idx + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MAX_STEPS); i++) begin
                mask_q[i] <= '0;
                min_q[i]  <= CNT_W'(1);
                max_q[i]  <= CNT_W'(1);
            end
            len_q <= '0;
        end else begin
            if (idle && we) begin
                mask_q[addr] <= mask;
                min_q[addr]  <= min_eff;
                max_q[addr]  <= max_eff;
            end
            if (idle && len_we) begin
                len_q <= len_eff;
            end
        end
    end

    assign rd_mask  = mask_q[rd_idx];
    assign rd_min   = min_q[rd_idx];
    assign rd_max   = max_q[rd_idx];
    assign nxt_mask = mask_q[nxt_idx];
    assign len      = len_q;

endmodule

// File: rtl/seq_pattern_matcher.sv
// Programmable greedy matcher for \0-delimited strings of classified characters.
//   clk, rst      : clock, synchronous active-high reset
//   valid, cls    : one class vector per valid beat, cls[0] marks \0
//   cfg_*         : step table and pattern length writes (IDLE only)
//   state         : IDLE=0 RUN=1 STOP=2 ERROR=3 ERR_TERM=4
//   step_idx      : current step, rep_cnt: characters taken in that step
//   match, error  : one-cycle result pulses
//   match_cnt, err_cnt : saturating statistics
module seq_pattern_matcher
    import seq_match_pkg::*;
#(
    parameter int unsigned NUM_CLASS = 14,
    parameter int unsigned MAX_STEPS = 8,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned STAT_W    = 16,
    localparam int unsigned AW       = $clog2(MAX_STEPS),
    localparam int unsigned LW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [NUM_CLASS-1:0] cls,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [NUM_CLASS-1:0] cfg_mask,
    input  logic [CNT_W-1:0]     cfg_min,
    input  logic [CNT_W-1:0]     cfg_max,
    input  logic                 cfg_len_we,
    input  logic [LW-1:0]        cfg_len,
    output logic [2:0]           state,
    output logic [AW-1:0]        step_idx,
    output logic [CNT_W-1:0]     rep_cnt,
    output logic                 match,
    output logic                 error,
    output logic [STAT_W-1:0]    match_cnt,
    output logic [STAT_W-1:0]    err_cnt
);

    state_e              state_q, state_d;
    logic [AW-1:0]       step_q, step_d;
    logic [CNT_W-1:0]    rep_q, rep_d;
    logic                match_q, match_d;
    logic                error_q, error_d;
    logic [STAT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [STAT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [NUM_CLASS-1:0] cur_mask, nxt_mask;
    logic [CNT_W-1:0]     cur_min, cur_max;
    logic [LW-1:0]        len;

    seq_cfg_table #(
        .NUM_CLASS (NUM_CLASS),
        .MAX_STEPS (MAX_STEPS),
        .CNT_W     (CNT_W)
    ) u_cfg_table (
        .clk      (clk),
        .rst      (rst),
        .idle     (state_q == StIdle),
        .we       (cfg_we),
        .addr     (cfg_addr),
        .mask     (cfg_mask),
        .min      (cfg_min),
        .max      (cfg_max),
        .len_we   (cfg_len_we),
        .len_in   (cfg_len),
        .rd_idx   (step_q),
        .rd_mask  (cur_mask),
        .rd_min   (cur_min),
        .rd_max   (cur_max),
        .nxt_mask (nxt_mask),
        .len      (len)
    );

    logic              is_term, hit_cur, hit_nxt, min_ok, at_last, has_next;
    logic [LW-1:0]     step_next_ext;
    logic [STAT_W-1:0] match_cnt_inc, err_cnt_inc;

    always_comb begin
        is_term       = cls[CLS_START_STOP];
        hit_cur       = |(cur_mask & cls);
        hit_nxt       = |(nxt_mask & cls);
        min_ok        = (rep_q >= cur_min);
        step_next_ext = LW'(step_q) + LW'(1);
        at_last       = (step_next_ext == len);
        has_next      = (step_next_ext < len);
        match_cnt_inc = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + STAT_W'(1);
        err_cnt_inc   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + STAT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        rep_d       = rep_q;
        match_d     = 1'b0;
        error_d     = 1'b0;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (valid && is_term) begin
                    state_d = StRun;
                    step_d  = '0;
                    rep_d   = '0;
                end
            end
            StRun: begin
                if (valid) begin
                    if (is_term) begin
                        if ((len == '0) || (at_last && min_ok)) begin
                            state_d     = StStop;
                            match_d     = 1'b1;
                            match_cnt_d = match_cnt_inc;
                        end else begin
                            state_d   = StErrTerm;
                            error_d   = 1'b1;
                            err_cnt_d = err_cnt_inc;
                        end
                    end else if (hit_cur && (rep_q < cur_max)) begin
                        rep_d = rep_q + CNT_W'(1);
                    end else if (has_next && min_ok && hit_nxt) begin
                        // Greedy: advance only once the current step can no longer absorb.
                        step_d = step_q + AW'(1);
                        rep_d  = CNT_W'(1);
                    end else begin
                        state_d   = StError;
                        error_d   = 1'b1;
                        err_cnt_d = err_cnt_inc;
                    end
                end
            end
            StStop, StErrTerm: begin
                state_d = StIdle;
            end
            StError: begin
                // The closing \0 only resynchronises; it does not start a new string.
                if (valid && is_term) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            rep_q       <= '0;
            match_q     <= 1'b0;
            error_q     <= 1'b0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            rep_q       <= rep_d;
            match_q     <= match_d;
            error_q     <= error_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign state     = state_q;
    assign step_idx  = step_q;
    assign rep_cnt   = rep_q;
    assign match     = match_q;
    assign error     = error_q;
    assign match_cnt = match_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seq_pattern_matcher.sv
// Bench for seq_pattern_matcher: directed scenarios plus randomised tables and
// strings, checked against a segment-wise greedy model of the matching rules.
module tb_seq_pattern_matcher;
    import seq_match_pkg::*;

    localparam int unsigned NC = 14;
    localparam int unsigned MS = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned SW = 4;
    localparam int unsigned AW = 3;
    localparam int unsigned LW = 4;
    localparam int         SAT = (1 << SW) - 1;

    typedef logic [NC-1:0] cv_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    cv_t           cls;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    cv_t           cfg_mask;
    logic [CW-1:0] cfg_min;
    logic [CW-1:0] cfg_max;
    logic          cfg_len_we;
    logic [LW-1:0] cfg_len;
    logic [2:0]    state;
    logic [AW-1:0] step_idx;
    logic [CW-1:0] rep_cnt;
    logic          match;
    logic          error;
    logic [SW-1:0] match_cnt;
    logic [SW-1:0] err_cnt;

    always #5 clk = ~clk;

    seq_pattern_matcher #(
        .NUM_CLASS (NC),
        .MAX_STEPS (MS),
        .CNT_W     (CW),
        .STAT_W    (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .cls        (cls),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_mask   (cfg_mask),
        .cfg_min    (cfg_min),
        .cfg_max    (cfg_max),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .state      (state),
        .step_idx   (step_idx),
        .rep_cnt    (rep_cnt),
        .match      (match),
        .error      (error),
        .match_cnt  (match_cnt),
        .err_cnt    (err_cnt)
    );

    // Character classes used by the stimulus.
    localparam cv_t Z      = cv_t'(1) << CLS_START_STOP;
    localparam cv_t C_PAR  = (cv_t'(1) << CLS_PAREN) | (cv_t'(1) << CLS_PUNCT_BASIC);
    localparam cv_t C_CAP  = (cv_t'(1) << CLS_CAPITAL) | (cv_t'(1) << CLS_HEX)
                           | (cv_t'(1) << CLS_VOWEL);
    localparam cv_t C_DIG  = (cv_t'(1) << CLS_NUMBER) | (cv_t'(1) << CLS_HEX);
    localparam cv_t C_PLUS = (cv_t'(1) << CLS_MATH) | (cv_t'(1) << CLS_PUNCT_BASIC);
    localparam cv_t C_SML  = (cv_t'(1) << CLS_SMALL) | (cv_t'(1) << CLS_CONSONANT);
    localparam cv_t C_WS   = cv_t'(1) << CLS_WS;
    localparam cv_t C_OTH  = cv_t'(1) << CLS_OTHER;
    localparam cv_t M_NC   = (cv_t'(1) << CLS_NUMBER) | (cv_t'(1) << CLS_CAPITAL);

    cv_t alpha [7];
    cv_t mask_pool [6];

    // Mirror of what the table should hold.
    cv_t t_mask [MS];
    int  t_min  [MS];
    int  t_max  [MS];
    int  t_len;

    int exp_mcnt, exp_ecnt;
    int n_cmp, n_fail;
    int inj_idx = -1;
    int inj_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? v : v + 1;
    endfunction

    // Walks the string one step-segment at a time: each step greedily swallows
    // characters up to its max; the character that stops it decides the outcome.
    // res: 0 accepted, 1 bad terminator, 2 mid-string error at index epos.
    function automatic void model(input cv_t s[$], output int res, output int epos,
                                  output int fk, output int fc);
        int p = 1;
        int k = 0;
        int c = 0;
        res = 2; epos = 0; fk = 0; fc = 0;
        while (p < s.size()) begin
            while (p < s.size() && !s[p][0] && ((t_mask[k] & s[p]) != 0) && c < t_max[k]) begin
                c++;
                p++;
            end
            if (p >= s.size()) break;
            fk = k; fc = c; epos = p;
            if (s[p][0]) begin
                res = (t_len == 0 || (k == t_len - 1 && c >= t_min[k])) ? 0 : 1;
                return;
            end
            if (k < t_len - 1 && c >= t_min[k] && ((t_mask[k+1] & s[p]) != 0)) begin
                k++;
                c = 1;
                p++;
            end else begin
                res = 2;
                return;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < int'(MS); i++) begin
            t_mask[i] = '0; t_min[i] = 1; t_max[i] = 1;
        end
        t_len = 0; exp_mcnt = 0; exp_ecnt = 0;
    endtask

    task automatic wr_step(input int a, input cv_t m, input int mn, input int mx);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_mask = m; cfg_min = CW'(mn); cfg_max = CW'(mx);
        tick();
        cfg_we = 1'b0;
        t_mask[a] = m;
        t_min[a]  = (mn == 0) ? 1 : mn;
        t_max[a]  = (mx < t_min[a]) ? t_min[a] : mx;
    endtask

    task automatic wr_len(input int l);
        cfg_len_we = 1'b1; cfg_len = LW'(l);
        tick();
        cfg_len_we = 1'b0;
        t_len = (l > int'(MS)) ? int'(MS) : l;
    endtask

    task automatic load_expr_table();
        wr_step(0, C_PAR, 1, 1);
        wr_step(1, M_NC, 1, 1);
        wr_step(2, cv_t'(1) << CLS_MATH, 1, 1);
        wr_step(3, M_NC, 1, 1);
        wr_step(4, C_PAR, 1, 1);
        wr_len(5);
    endtask

    task automatic send(input cv_t s[$]);
        int res, epos, fk, fc;
        model(s, res, epos, fk, fc);
        for (int i = 0; i < s.size(); i++) begin
            valid = 1'b1; cls = s[i];
            if (i == inj_idx) begin
                cfg_len_we = 1'b1; cfg_len = LW'(inj_len);
            end
            tick();
            valid = 1'b0; cfg_len_we = 1'b0;
            if (res == 2 && i == epos) begin
                exp_ecnt = sat_inc(exp_ecnt);
                check("err_state", 32'(state), 32'(ST_ERROR));
                check("err_pulse", 32'(error), 32'd1);
                check("err_step", 32'(step_idx), 32'(fk));
                check("err_rep", 32'(rep_cnt), 32'(fc));
                check("err_cnt", 32'(err_cnt), 32'(exp_ecnt));
            end
        end
        if (res == 0) begin
            exp_mcnt = sat_inc(exp_mcnt);
            check("stop_state", 32'(state), 32'(ST_STOP));
            check("match_pulse", 32'(match), 32'd1);
            check("stop_step", 32'(step_idx), 32'(fk));
            check("stop_rep", 32'(rep_cnt), 32'(fc));
        end else if (res == 1) begin
            exp_ecnt = sat_inc(exp_ecnt);
            check("eterm_state", 32'(state), 32'(ST_ERR_TERM));
            check("eterm_pulse", 32'(error), 32'd1);
            check("eterm_step", 32'(step_idx), 32'(fk));
            check("eterm_rep", 32'(rep_cnt), 32'(fc));
        end else begin
            check("err_release", 32'(state), 32'(ST_IDLE));
            check("err_no_pulse", 32'(error), 32'd0);
        end
        tick();
        check("back_idle", 32'(state), 32'(ST_IDLE));
        check("idle_match", 32'(match), 32'd0);
        check("idle_error", 32'(error), 32'd0);
        check("match_cnt", 32'(match_cnt), 32'(exp_mcnt));
        check("err_cnt_end", 32'(err_cnt), 32'(exp_ecnt));
        inj_idx = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        cv_t s[$];
        cv_t expr[$];
        alpha     = '{C_PAR, C_CAP, C_DIG, C_PLUS, C_SML, C_WS, C_OTH};
        mask_pool = '{cv_t'(1) << CLS_PAREN, cv_t'(1) << CLS_NUMBER, cv_t'(1) << CLS_CAPITAL,
                      cv_t'(1) << CLS_SMALL, cv_t'(1) << CLS_MATH, cv_t'(1) << CLS_HEX};
        n_cmp = 0; n_fail = 0;
        cls = '0; cfg_addr = '0; cfg_mask = '0; cfg_min = '0; cfg_max = '0; cfg_len = '0;
        expr = '{Z, C_PAR, C_CAP, C_PLUS, C_DIG, C_PAR, Z};

        // Reset state.
        do_reset();
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_step", 32'(step_idx), 32'd0);
        check("rst_rep", 32'(rep_cnt), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_mcnt", 32'(match_cnt), 32'd0);
        check("rst_ecnt", 32'(err_cnt), 32'd0);

        // Expression pattern.
        load_expr_table();
        send(expr);

        // number{2,3}: accept, short, overlong.
        wr_step(0, cv_t'(1) << CLS_NUMBER, 2, 3);
        wr_len(1);
        s = '{Z, C_DIG, C_DIG, Z};               send(s);
        s = '{Z, C_DIG, Z};                      send(s);
        s = '{Z, C_DIG, C_DIG, C_DIG, C_DIG, Z}; send(s);

        // Greedy with no backtracking.
        wr_step(0, cv_t'(1) << CLS_NUMBER, 1, 3);
        wr_step(1, cv_t'(1) << CLS_NUMBER, 1, 1);
        wr_len(2);
        s = '{Z, C_DIG, C_DIG, C_DIG, Z}; send(s);

        // Length write during RUN is dropped, the same write in IDLE lands.
        load_expr_table();
        inj_idx = 2; inj_len = 1;
        send(expr);
        wr_len(1);
        send(expr);
        s = '{Z, C_PAR, Z}; send(s);

        // Write on the same edge as the starting \0 is used by that string.
        inj_idx = 0; inj_len = 5; t_len = 5;
        send(expr);

        // Reset in the middle of a string.
        valid = 1'b1; cls = Z;     tick();
        cls = C_PAR;               tick();
        cls = C_CAP;               tick();
        valid = 1'b0;
        do_reset();
        check("mid_rst_state", 32'(state), 32'(ST_IDLE));
        check("mid_rst_step", 32'(step_idx), 32'd0);
        check("mid_rst_rep", 32'(rep_cnt), 32'd0);
        check("mid_rst_pulses", 32'({match, error}), 32'd0);
        check("mid_rst_cnts", 32'({match_cnt, err_cnt}), 32'd0);
        load_expr_table();
        send(expr);

        // Length above MAX_STEPS clamps to a full eight-step table.
        for (int i = 0; i < int'(MS); i++) wr_step(i, cv_t'(1) << CLS_NUMBER, 1, 1);
        wr_len(12);
        s = '{Z};
        for (int i = 0; i < int'(MS); i++) s.push_back(C_DIG);
        s.push_back(Z);
        send(s);
        void'(s.pop_back());
        void'(s.pop_back());
        s.push_back(Z);
        send(s);

        // Randomised tables and strings.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 4; i++)
                wr_step(i, mask_pool[$urandom_range(0, 5)], $urandom_range(0, 3),
                        $urandom_range(0, 3));
            wr_len($urandom_range(0, 4));
            for (int n = 0; n < 10; n++) begin
                s = '{Z};
                if ($urandom_range(0, 1) == 1) begin
                    for (int k = 0; k < t_len; k++) begin
                        int reps = $urandom_range(t_min[k], t_max[k]);
                        for (int j = 0; j < reps; j++)
                            s.push_back(t_mask[k] | alpha[$urandom_range(0, 6)]);
                    end
                end else begin
                    int len = $urandom_range(0, 6);
                    for (int j = 0; j < len; j++) s.push_back(alpha[$urandom_range(0, 6)]);
                end
                s.push_back(Z);
                send(s);
            end
        end

        // Statistics saturate.
        do_reset();
        s = '{Z, Z};
        for (int i = 0; i < SAT + 2; i++) send(s);
        check("mcnt_saturated", 32'(match_cnt), 32'(SAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
